// File: rtl/btb_next_pc.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Produces the predicted next fetch PC; trained from the EX stage.
module btb_next_pc #(
   parameter int IndexBits = 4,
   parameter int AddrBits  = 32
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                ClockEnable,
   input  logic [AddrBits-1:0] PC,
   input  logic                UpdEn,
   input  logic [AddrBits-1:0] UpdPC,
   input  logic                UpdTaken,
   input  logic [AddrBits-1:0] UpdTarget,
   output logic                Hit,
   output logic                PredTaken,
   output logic [AddrBits-1:0] PredTarget,
   output logic [AddrBits-1:0] NextPC
);

   localparam int Entries = 1 << IndexBits;
   localparam int TagBits = AddrBits - IndexBits - 2;

   logic                valid_q  [Entries];
   logic [TagBits-1:0]  tag_q    [Entries];
   logic [AddrBits-1:0] target_q [Entries];
   logic [1:0]          ctr_q    [Entries];

   logic [IndexBits-1:0] lk_idx;
   logic [TagBits-1:0]   lk_tag;
   logic [IndexBits-1:0] up_idx;
   logic [TagBits-1:0]   up_tag;
   logic                 up_match;

   assign lk_idx = PC[IndexBits+1:2];
   assign lk_tag = PC[AddrBits-1:IndexBits+2];
   assign up_idx = UpdPC[IndexBits+1:2];
   assign up_tag = UpdPC[AddrBits-1:IndexBits+2];

   // Invalid entries are masked so stale tag/target bits never leak out.
   assign Hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign PredTaken  = Hit && ctr_q[lk_idx][1];
   assign PredTarget = Hit ? target_q[lk_idx] : '0;
   assign NextPC     = PredTaken ? PredTarget : PC + AddrBits'(4);

   assign up_match = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < Entries; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b00;
         end
      end else if (ClockEnable && UpdEn) begin
         if (up_match) begin
            if (UpdTaken) begin
               if (ctr_q[up_idx] != 2'b11)
                  ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
               target_q[up_idx] <= UpdTarget;
            end else if (ctr_q[up_idx] != 2'b00) begin
               ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
            end
         end else if (UpdTaken) begin
            // Taken miss: allocate weakly taken, evicting any alias.
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= UpdTarget;
            ctr_q[up_idx]    <= 2'b10;
         end
      end
   end

endmodule

// File: tb/tb_btb_next_pc.sv
// Directed self-checking bench for btb_next_pc.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_btb_next_pc;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        ClockEnable = 1'b1;
   logic [31:0] PC = '0;
   logic        UpdEn = 1'b0;
   logic [31:0] UpdPC = '0;
   logic        UpdTaken = 1'b0;
   logic [31:0] UpdTarget = '0;
   logic        Hit;
   logic        PredTaken;
   logic [31:0] PredTarget;
   logic [31:0] NextPC;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 Clock = ~Clock;

   btb_next_pc #(.IndexBits(4), .AddrBits(32)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .ClockEnable(ClockEnable),
      .PC(PC),
      .UpdEn(UpdEn),
      .UpdPC(UpdPC),
      .UpdTaken(UpdTaken),
      .UpdTarget(UpdTarget),
      .Hit(Hit),
      .PredTaken(PredTaken),
      .PredTarget(PredTarget),
      .NextPC(NextPC)
   );

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic update(input logic [31:0] a, input logic t,
                         input logic [31:0] tgt);
      UpdEn = 1'b1;
      UpdPC = a;
      UpdTaken = t;
      UpdTarget = tgt;
      tick();
      UpdEn = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      PC = 32'h0040_0010;
      #2;
      tests_run++;
      if (Hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_hit got %0b want 0", Hit);
      end
      tests_run++;
      if (PredTaken !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_pred got %0b want 0", PredTaken);
      end
      tests_run++;
      if (PredTarget !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_target got %h want 0", PredTarget);
      end
      tests_run++;
      if (NextPC !== 32'h0040_0014) begin
         tests_failed++;
         $display("FAIL reset_nextpc got %h want 00400014", NextPC);
      end
   endtask

   task automatic test_allocate();
      update(32'h0040_0010, 1'b1, 32'h0040_0100);
      PC = 32'h0040_0010;
      #2;
      tests_run++;
      if ({Hit, PredTaken} !== 2'b11) begin
         tests_failed++;
         $display("FAIL alloc_hit got %b want 11", {Hit, PredTaken});
      end
      tests_run++;
      if (NextPC !== 32'h0040_0100) begin
         tests_failed++;
         $display("FAIL alloc_nextpc got %h want 00400100", NextPC);
      end
      PC = 32'h0040_0013;
      #2;
      tests_run++;
      if (NextPC !== 32'h0040_0100) begin
         tests_failed++;
         $display("FAIL alloc_lowbits got %h want 00400100", NextPC);
      end
   endtask

   task automatic test_counter();
      PC = 32'h0040_0010;
      repeat (3) update(32'h0040_0010, 1'b1, 32'h0040_0100);
      update(32'h0040_0010, 1'b0, 32'h0);
      #2;
      tests_run++;
      if (PredTaken !== 1'b1) begin
         tests_failed++;
         $display("FAIL ctr2_pred got %0b want 1", PredTaken);
      end
      update(32'h0040_0010, 1'b0, 32'h0);
      #2;
      tests_run++;
      if ({Hit, PredTaken} !== 2'b10) begin
         tests_failed++;
         $display("FAIL ctr1_hitpred got %b want 10", {Hit, PredTaken});
      end
      tests_run++;
      if (NextPC !== 32'h0040_0014) begin
         tests_failed++;
         $display("FAIL ctr1_nextpc got %h want 00400014", NextPC);
      end
      tests_run++;
      if (PredTarget !== 32'h0040_0100) begin
         tests_failed++;
         $display("FAIL ctr1_target got %h want 00400100", PredTarget);
      end
      // 1 -> 0 -> 0 -> 1 must still predict not-taken, then 2 taken.
      update(32'h0040_0010, 1'b0, 32'h0);
      update(32'h0040_0010, 1'b0, 32'h0);
      update(32'h0040_0010, 1'b1, 32'h0040_0100);
      #2;
      tests_run++;
      if ({Hit, PredTaken} !== 2'b10) begin
         tests_failed++;
         $display("FAIL ctr_floor got %b want 10", {Hit, PredTaken});
      end
      update(32'h0040_0010, 1'b1, 32'h0040_0180);
      #2;
      tests_run++;
      if (NextPC !== 32'h0040_0180) begin
         tests_failed++;
         $display("FAIL ctr_retarget got %h want 00400180", NextPC);
      end
   endtask

   task automatic test_alias();
      update(32'h0040_0050, 1'b1, 32'h0040_0200);
      PC = 32'h0040_0010;
      #2;
      tests_run++;
      if ({Hit, NextPC} !== {1'b0, 32'h0040_0014}) begin
         tests_failed++;
         $display("FAIL alias_evict got %b/%h want 0/00400014", Hit, NextPC);
      end
      PC = 32'h0040_0050;
      #2;
      tests_run++;
      if ({Hit, NextPC} !== {1'b1, 32'h0040_0200}) begin
         tests_failed++;
         $display("FAIL alias_new got %b/%h want 1/00400200", Hit, NextPC);
      end
   endtask

   task automatic test_same_cycle();
      PC = 32'h0040_0020;
      UpdEn = 1'b1;
      UpdPC = 32'h0040_0020;
      UpdTaken = 1'b1;
      UpdTarget = 32'h0040_0300;
      #2;
      tests_run++;
      if (Hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL same_cycle_hit got %0b want 0", Hit);
      end
      tick();
      UpdEn = 1'b0;
      #2;
      tests_run++;
      if ({Hit, NextPC} !== {1'b1, 32'h0040_0300}) begin
         tests_failed++;
         $display("FAIL next_cycle got %b/%h want 1/00400300", Hit, NextPC);
      end
      update(32'h0040_0030, 1'b0, 32'h0040_0700);
      PC = 32'h0040_0030;
      #2;
      tests_run++;
      if ({Hit, NextPC} !== {1'b0, 32'h0040_0034}) begin
         tests_failed++;
         $display("FAIL nt_noalloc got %b/%h want 0/00400034", Hit, NextPC);
      end
   endtask

   task automatic test_reset_priority();
      Reset = 1'b1;
      update(32'h0040_0040, 1'b1, 32'h0040_0400);
      Reset = 1'b0;
      PC = 32'h0040_0020;
      #2;
      tests_run++;
      if (Hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_clears got %0b want 0", Hit);
      end
      PC = 32'h0040_0040;
      #2;
      tests_run++;
      if ({Hit, NextPC} !== {1'b0, 32'h0040_0044}) begin
         tests_failed++;
         $display("FAIL rst_drops got %b/%h want 0/00400044", Hit, NextPC);
      end
   endtask

   task automatic test_clock_enable();
      update(32'h0040_0010, 1'b1, 32'h0040_0100);
      ClockEnable = 1'b0;
      update(32'h0040_0060, 1'b1, 32'h0040_0500);
      update(32'h0040_0010, 1'b0, 32'h0);
      update(32'h0040_0010, 1'b0, 32'h0);
      PC = 32'h0040_0060;
      #2;
      tests_run++;
      if (Hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL ce_noalloc got %0b want 0", Hit);
      end
      PC = 32'h0040_0010;
      #2;
      tests_run++;
      if (NextPC !== 32'h0040_0100) begin
         tests_failed++;
         $display("FAIL ce_hold got %h want 00400100", NextPC);
      end
      ClockEnable = 1'b1;
   endtask

   task automatic test_wrap();
      PC = 32'hFFFF_FFFC;
      #2;
      tests_run++;
      if ({Hit, NextPC} !== {1'b0, 32'h0}) begin
         tests_failed++;
         $display("FAIL wrap got %b/%h want 0/00000000", Hit, NextPC);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_allocate();
      test_counter();
      test_alias();
      test_same_cycle();
      test_reset_priority();
      test_clock_enable();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/btb_next_pc.md
Name: btb_next_pc

Overview:
- Direct-mapped branch target buffer with 2-bit saturating predictors. Sits in the IF stage directly upstream of the PC register.
- Takes the current PC and produces the predicted next PC, which is written into the PC register on the next Clock edge.
- Gets training updates from the EX stage, where branch outcome and target are resolved.

Parameters:
- IndexBits, 4, log2 of entry count; 16 entries by default.
- AddrBits, 32, width of PC and target addresses.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; clears all valid bits.
- ClockEnable  in  1  global enable; when 0, no state changes except Reset.
- PC  in  AddrBits  current fetch address, from PC register Q.
- UpdEn  in  1  EX-stage branch/jump resolved this cycle.
- UpdPC  in  AddrBits  address of the resolved branch.
- UpdTaken  in  1  resolved outcome.
- UpdTarget  in  AddrBits  resolved taken target.
- Hit  out  1  valid entry with matching tag for PC.
- PredTaken  out  1  Hit and counter[1] of the indexed entry.
- PredTarget  out  AddrBits  stored target of the indexed entry; 0 when not Hit.
- NextPC  out  AddrBits  PredTaken ? PredTarget : PC+4; feeds PC register D.

Behaviour:
- Index = addr[IndexBits+1:2]; tag = addr[AddrBits-1:IndexBits+2]; addr[1:0] is ignored.
- Entry storage: valid (1 bit), tag, target (AddrBits), ctr (2 bits).
- Lookup is combinational from PC and stored state, with zero-cycle latency.
- NextPC is PC+4 computed modulo 2^AddrBits, so 0xFFFFFFFC wraps to 0x00000000.
- Reset (sampled at the rising edge) clears valid[all] and sets ctr[all]=2'b00.
- Reset has priority over UpdEn and ClockEnable.
- After Reset, until the first update: Hit=0, PredTaken=0, PredTarget=0, NextPC=PC+4.
- Updates happen only on a rising edge with ClockEnable=1, UpdEn=1 and Reset=0. Let e be the entry at index(UpdPC); "match" means e.valid and e.tag==tag(UpdPC).
  - Match and UpdTaken=1: ctr saturating increment (3 stays 3); target <= UpdTarget.
  - Match and UpdTaken=0: ctr saturating decrement (0 stays 0); target is unchanged; the entry stays valid.
  - No match and UpdTaken=1: allocate by overwriting e with valid=1, tag=tag(UpdPC), target=UpdTarget, ctr=2'b10 (weakly taken).
  - No match and UpdTaken=0: no change. Not-taken branches are never allocated.
- Lookup and update on the same cycle at the same index: the lookup returns pre-update contents. The update becomes visible one cycle after the edge; there is no write-through bypass.
- Only one update port exists, so at most one entry changes per cycle.
- ClockEnable=0 holds all state; the combinational outputs still track PC.
- Aliasing: two branches with the same index but different tags evict each other only through taken-miss allocation.
- Outputs never go X or Z. Unused tag/target bits of invalid entries are don't-care internally but must not reach the outputs.

Test Plan:
- Reset, then PC=0x00400010 -> Hit=0, PredTaken=0, NextPC=0x00400014.
- Update UpdPC=0x00400010, Taken=1, Target=0x00400100; next cycle PC=0x00400010 -> Hit=1, PredTaken=1, NextPC=0x00400100, ctr=2.
- Three more taken updates, then two not-taken updates to the same entry -> ctr sequence 3,3,3,2,1. After this, PredTaken=0, NextPC=0x00400014, Hit=1.
- Entry at 0x00400010 valid; taken update from aliasing 0x00400050 (same index, 16 entries), Target=0x00400200 -> PC=0x00400010 gives Hit=0; PC=0x00400050 gives NextPC=0x00400200.
- Same-cycle update and lookup on 0x00400020 (previously empty) -> Hit=0 that cycle, Hit=1 the following cycle. Not-taken update to an empty entry -> Hit stays 0.
- Reset asserted the same cycle as a taken update -> all valid cleared and the update is dropped. ClockEnable=0 with UpdEn=1 -> no change. PC=0xFFFFFFFC on a miss -> NextPC=0x00000000.
